// File: rtl/bank_access_ctrl_if.sv
// Signal bundle between bank_access_ctrl and its neighbours: keypad, clear request,
// VGA read address and the register bank ports.
interface bank_access_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 3
) ();
    logic              key_valid;
    logic [ADDR_W-1:0] key_pos;
    logic              clr_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_w;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_own;
    logic              busy;
    logic [7:0]        edit_cnt;

    // Environment side: keypad, clear source, VGA block and bank read data
    modport master (
        output key_valid, key_pos, clr_req, vga_addr, rd_data,
        input  addr_r, addr_w, wr_en, wr_data, rd_own, busy, edit_cnt
    );

    // Controller side
    modport slave (
        input  key_valid, key_pos, clr_req, vga_addr, rd_data,
        output addr_r, addr_w, wr_en, wr_data, rd_own, busy, edit_cnt
    );
endinterface

// File: rtl/bank_access_ctrl.sv
// Register-bank access controller: keypad read-modify-write colour advance and clear sweep.
// Optional keypad edit counter is built only when BANK_EDIT_CNT_EN is defined.
module bank_access_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 3,
    parameter int CLR_COLOR = 0
) (
    input  logic                clk,
    input  logic                rst,
    bank_access_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WRITE    = 3'd2,
        ST_WAIT_REL = 3'd3,
        ST_CLEAR    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] CLR_WORD  = DATA_W'(CLR_COLOR);

    // Next colour in the cycle; the top colour wraps naturally to zero.
    function automatic logic [DATA_W-1:0] next_color(input logic [DATA_W-1:0] c);
        return c + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    state_t            state_r;
    logic [ADDR_W-1:0] pos_q_r;
    logic              key_prev_r;
    logic [ADDR_W-1:0] addr_w_r;
    logic              wr_en_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              busy_r;
    logic              press_edge_s;
    logic              last_addr_s;

    // Press edge detection and end-of-sweep decode
    always_comb begin
        press_edge_s = bus.key_valid & ~key_prev_r;
        last_addr_s  = (addr_w_r == ADDR_LAST);
    end

    // Main controller FSM with registered bank-write outputs.
    // The captured read word is folded straight into wr_data_r so the
    // write data is already registered during the WRITE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            pos_q_r    <= ADDR_ZERO;
            key_prev_r <= 1'b0;
            addr_w_r   <= ADDR_ZERO;
            wr_en_r    <= 1'b0;
            wr_data_r  <= DATA_ZERO;
            busy_r     <= 1'b0;
        end else begin
            key_prev_r <= bus.key_valid;
            case (state_r)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state_r   <= ST_CLEAR;
                        addr_w_r  <= ADDR_ZERO;
                        wr_en_r   <= 1'b1;
                        wr_data_r <= CLR_WORD;
                        busy_r    <= 1'b1;
                    end else if (press_edge_s) begin
                        state_r <= ST_READ;
                        pos_q_r <= bus.key_pos;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    state_r   <= ST_WRITE;
                    addr_w_r  <= pos_q_r;
                    wr_data_r <= next_color(bus.rd_data);
                    wr_en_r   <= 1'b1;
                end
                ST_WRITE: begin
                    state_r <= ST_WAIT_REL;
                    wr_en_r <= 1'b0;
                end
                ST_WAIT_REL: begin
                    if (bus.clr_req) begin
                        state_r   <= ST_CLEAR;
                        addr_w_r  <= ADDR_ZERO;
                        wr_en_r   <= 1'b1;
                        wr_data_r <= CLR_WORD;
                    end else if (!bus.key_valid) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_WAIT_REL;
                    end
                end
                ST_CLEAR: begin
                    if (last_addr_s) begin
                        state_r <= ST_IDLE;
                        wr_en_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        addr_w_r <= addr_w_r + ADDR_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    wr_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BANK_EDIT_CNT_EN
    logic [7:0] edit_cnt_r;
    logic       clear_entry_s;

    // A sweep starts from IDLE or WAIT_REL whenever clr_req is seen there
    always_comb begin
        clear_entry_s = 1'b0;
        if (((state_r == ST_IDLE) || (state_r == ST_WAIT_REL)) && bus.clr_req) begin
            clear_entry_s = 1'b1;
        end else begin
            clear_entry_s = 1'b0;
        end
    end

    // Saturating count of keypad edits, zeroed when a sweep begins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edit_cnt_r <= 8'h00;
        end else if (clear_entry_s) begin
            edit_cnt_r <= 8'h00;
        end else if ((state_r == ST_WRITE) && (edit_cnt_r != 8'hFF)) begin
            edit_cnt_r <= edit_cnt_r + 8'h01;
        end else begin
            edit_cnt_r <= edit_cnt_r;
        end
    end

    assign bus.edit_cnt = edit_cnt_r;
`else
    assign bus.edit_cnt = 8'h00;
`endif

    // The controller borrows the read port only for its single READ cycle
    assign bus.rd_own  = (state_r == ST_READ);
    assign bus.addr_r  = (state_r == ST_READ) ? pos_q_r : bus.vga_addr;
    assign bus.addr_w  = addr_w_r;
    assign bus.wr_en   = wr_en_r;
    assign bus.wr_data = wr_data_r;
    assign bus.busy    = busy_r;

endmodule

// File: doc/bank_access_ctrl.md
Name: bank_access_ctrl

Overview:
- Owns the register bank's write port and time-shares its single read port between the VGA scanner and itself.
- Turns each keypad press into a read-modify-write that advances the stored 3-bit colour of the pressed cell to the next colour.
- Runs a clear-all sweep on request.
- Sits between the keypad decoder, the register bank and the VGA test-pattern block in the top level.

Parameters:
- ADDR_W, 4: bank address width; the bank holds 2**ADDR_W cells.
- DATA_W, 3: colour word width.
- CLR_COLOR, 0: value written to every cell by a clear sweep.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- key_valid  in  1  keypad key-held level (keypad opr output)
- key_pos  in  ADDR_W  keypad cell position; valid while key_valid=1
- clr_req  in  1  clear-all request, level; sampled in IDLE and WAIT_REL
- vga_addr  in  ADDR_W  read address requested by the VGA block
- rd_data  in  DATA_W  bank combinational read data for addr_r
- addr_r  out  ADDR_W  bank read address (muxed)
- addr_w  out  ADDR_W  bank write address
- wr_en  out  1  bank write strobe, one clk per word
- wr_data  out  DATA_W  bank write data
- rd_own  out  1  1 while the controller owns the read port
- busy  out  1  1 in any state other than IDLE
- edit_cnt  out  8  keypad edit counter (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, addr_w=0, wr_en=0, wr_data=0, pos_q=0, key_prev=0, busy=0, rd_own=0, edit_cnt=0.
- key_prev samples key_valid every clk in every state. A press edge is key_valid=1 & key_prev=0.
- addr_r = pos_q when state=READ, else vga_addr (combinational mux). rd_own = (state==READ).
- IDLE:
  - clr_req=1 → CLEAR, addr_w=0. clr_req takes priority over a simultaneous press edge; that edge is lost.
  - Otherwise a press edge → pos_q=key_pos, go to READ.
- READ (1 clk):
  - rd_data is captured at the end of the cycle into dat_q.
  - VGA sees pos_q's data for exactly this one cycle. This is an accepted one-pixel artefact.
  - → WRITE.
- WRITE (1 clk):
  - wr_en=1, addr_w=pos_q, wr_data=(dat_q+1) mod 2**DATA_W. The value 7 wraps to 0.
  - → WAIT_REL.
- WAIT_REL:
  - clr_req=1 → CLEAR.
  - key_valid=0 → IDLE.
  - Otherwise stay. A held key produces exactly one edit.
- CLEAR:
  - wr_en=1 every clk, wr_data=CLR_COLOR. addr_w runs 0,1,…,2**ADDR_W-1 (16 clks at default).
  - After the last address → IDLE.
  - key_valid and clr_req are ignored during the sweep. A key still held at exit gives no edge.
  - clr_req still high at exit starts another sweep.
- Latency: press edge at cycle N → wr_en at N+2 (READ at N+1).
- Outputs are registered except addr_r and rd_own.
- Reset asserted mid-operation aborts immediately; no partial-word write completes after rst falls.
- wr_en is never asserted in IDLE, READ or WAIT_REL.

Optional Feature:
- Macro: BANK_EDIT_CNT_EN.
- Defined:
  - edit_cnt increments by 1 on each WRITE-state write, saturating at 255.
  - edit_cnt is cleared to 0 on entry to CLEAR.
- Undefined: edit_cnt is tied to 0 and the counter logic is not built.

Test Plan:
- Reset release, bank cell 5=3: pulse key_valid high with key_pos=5 for 10 clks → exactly one wr_en, addr_w=5, wr_data=4, two clks after the edge.
- Cell 9=7: press pos 9 → wr_data=0 (wrap). rd_own=1 for exactly one clk, and addr_r=9 during that clk. addr_r otherwise tracks vga_addr.
- clr_req high for 1 clk in IDLE with CLR_COLOR=0 → 16 consecutive wr_en pulses at addr_w 0..15, wr_data=0, then busy=0.
- Key held on pos 2 across a clear sweep, then released and pressed again → no write after the sweep; one write to addr 2 after the re-press.
- press edge and clr_req asserted in the same IDLE cycle → clear sweep only, no write at key_pos. With BANK_EDIT_CNT_EN defined: 3 edits → edit_cnt=3, then a clear → edit_cnt=0.
- Drive rst low during CLEAR at addr_w=6 → wr_en=0 and state=IDLE immediately. After release, no write occurs without a new edge or clr_req.
